commit_trace_buf: RTL

- Downstream consumer of the core's architectural-commit outputs: register writeback (RegWriteSignal/RegNum/RegData) and data-memory store (WR/Address/WRData).
- Captures each commit event into an internal FIFO and drains it over a ready/valid trace port to the debug/log sink.
- Lost events are accounted for with an in-band overflow marker record.
- Purely observational: it never back-pressures the core.

---
 rtl/commit_trace_pkg.sv | 34 +++
 rtl/commit_trace_buf_fifo.sv | 76 +++++++
 rtl/commit_trace_buf.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared types for the commit trace buffer.
//   kind_e      - record kind carried on tr_kind
//   state_e     - overflow-marker FSM state
//   trace_rec_t - one FIFO entry; the stamp field exists only when
//                 COMMIT_TRACE_STAMP_EN is defined, so the default build
//                 carries no timestamp storage.
package commit_trace_pkg;

  localparam int REC_DATA_W = 32;  // record data field width
  localparam int STAMP_W    = 16;
  localparam int IDX_W      = 9;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_REG  = 2'b01,
    KIND_ST   = 2'b10,
    KIND_OVF  = 2'b11
  } kind_e;

  typedef enum logic {
    RUN  = 1'b0,
    MARK = 1'b1
  } state_e;

  typedef struct packed {
    kind_e                   kind;
    logic [IDX_W-1:0]        idx;
    logic [REC_DATA_W-1:0]   data;
`ifdef COMMIT_TRACE_STAMP_EN
    logic [STAMP_W-1:0]      stamp;
`endif
  } trace_rec_t;

endpackage

// File: rtl/commit_trace_buf_fifo.sv
// trace_fifo2w: dual-write, single-read FIFO with a registered head.
//   push0/din0 - first (older) write port
//   push1/din1 - second (younger) write port; lands behind din0 when both fire
//   pop        - consume the head (ignored while empty)
//   valid/dout - registered head entry (first-word-fall-through)
//   level      - occupancy, 0..DEPTH
//   free       - slots available this cycle, counting the slot freed by pop
// The caller must never push more than 'free' entries in a cycle.
module trace_fifo2w #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push0,
  input  logic [W-1:0] din0,
  input  logic         push1,
  input  logic [W-1:0] din1,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic [AW:0]  free
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wptr, rptr, wptr_nx, rptr_nx;
  logic [AW:0]   n_push, level_pop, level_nx;
  logic [AW-1:0] w0, w1;
  logic          full, pop_ok;
  logic [W-1:0]  head_nx;

  assign pop_ok = pop & valid;

  // Wrap bit distinguishes full from empty when the low bits match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = full ? (AW+1)'(DEPTH) : {1'b0, wptr[AW-1:0] - rptr[AW-1:0]};
  assign free  = (AW+1)'(DEPTH) - level + (AW+1)'(pop_ok);

  assign n_push    = (AW+1)'(push0) + (AW+1)'(push1);
  assign rptr_nx   = rptr + (AW+1)'(pop_ok);
  assign wptr_nx   = wptr + n_push;
  assign level_pop = level - (AW+1)'(pop_ok);
  assign level_nx  = level_pop + n_push;

  assign w0 = wptr[AW-1:0];
  assign w1 = wptr[AW-1:0] + AW'(1);

  // Next head: if nothing older survives the pop, the head comes straight
  // from this cycle's first write (bypass), otherwise from storage.
  always_comb begin
    head_nx = mem[rptr_nx[AW-1:0]];
    if (level_pop == '0) head_nx = push0 ? din0 : din1;
  end

  always_ff @(posedge clk) begin
    if (push0) mem[w0] <= din0;
    if (push1) mem[push0 ? w1 : w0] <= din1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      wptr  <= wptr_nx;
      rptr  <= rptr_nx;
      valid <= (level_nx != '0);
      if (level_nx != '0) dout <= head_nx;
    end
  end

endmodule

// File: rtl/commit_trace_buf.sv
// commit_trace_buf: captures architectural commit events (register
// writeback, data-memory store) into a FIFO and drains them over a
// ready/valid trace port. Never back-pressures the core: events that do not
// fit are dropped, counted, and reported later by an in-band marker record.
//   clk, rst                 - clock, async active-low reset
//   trace_en                 - capture enable
//   RegWriteSignal/RegNum/RegData - register commit (RegNum 0 ignored)
//   WR/Address/WRData        - store commit
//   tr_valid/tr_ready        - trace handshake
//   tr_kind/tr_idx/tr_data   - record (01 reg, 10 store, 11 overflow marker)
//   tr_stamp                 - capture cycle stamp, 0 unless stamping built in
//   ovf_sticky               - set on any drop until reset
//   level                    - FIFO occupancy
// Build option: define COMMIT_TRACE_STAMP_EN to store a 16-bit free-running
// cycle stamp with every record.
import commit_trace_pkg::*;

module commit_trace_buf #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  parameter  int CNT_W  = 16,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_en,
  input  logic              RegWriteSignal,
  input  logic [4:0]        RegNum,
  input  logic [DATA_W-1:0] RegData,
  input  logic              WR,
  input  logic [8:0]        Address,
  input  logic [DATA_W-1:0] WRData,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [1:0]        tr_kind,
  output logic [8:0]        tr_idx,
  output logic [DATA_W-1:0] tr_data,
  output logic [STAMP_W-1:0] tr_stamp,
  output logic              ovf_sticky,
  output logic [LW-1:0]     level
);

  state_e           state_q, state_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_sum;
  logic [CNT_W:0]   sum_wide;
  logic             ovf_q;

  logic             ev_reg, ev_st, push0, push1, mark_push, fifo_valid;
  logic [1:0]       need, drops;
  logic [LW-1:0]    free, fifo_level;
  trace_rec_t       rec_reg, rec_st, rec_mark, din0, head;

`ifdef COMMIT_TRACE_STAMP_EN
  logic [STAMP_W-1:0] stamp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stamp_q <= '0;
    else      stamp_q <= stamp_q + 1'b1;
  end
`endif

  assign ev_reg = trace_en & RegWriteSignal & (RegNum != 5'd0);
  assign ev_st  = trace_en & WR;
  assign need   = {1'b0, ev_reg} + {1'b0, ev_st};

  // Drops saturate; the marker reports everything lost up to and including
  // its own push cycle, so the count restarts from zero afterwards.
  assign sum_wide = {1'b0, cnt_q} + (CNT_W+1)'(drops);
  assign cnt_sum  = sum_wide[CNT_W] ? '1 : sum_wide[CNT_W-1:0];
  assign cnt_nx   = mark_push ? '0 : cnt_sum;

  always_comb begin
    rec_reg       = '0;
    rec_reg.kind  = KIND_REG;
    rec_reg.idx   = IDX_W'(RegNum);
    rec_reg.data  = REC_DATA_W'(RegData);
    rec_st        = '0;
    rec_st.kind   = KIND_ST;
    rec_st.idx    = Address;
    rec_st.data   = REC_DATA_W'(WRData);
    rec_mark      = '0;
    rec_mark.kind = KIND_OVF;
    rec_mark.data = REC_DATA_W'(cnt_sum);
`ifdef COMMIT_TRACE_STAMP_EN
    rec_reg.stamp  = stamp_q;
    rec_st.stamp   = stamp_q;
    rec_mark.stamp = stamp_q;
`endif
  end

  always_comb begin
    state_nx  = state_q;
    push0     = 1'b0;
    push1     = 1'b0;
    mark_push = 1'b0;
    drops     = 2'd0;
    case (state_q)
      RUN: begin
        if (LW'(need) <= free) begin
          push0 = ev_reg;
          push1 = ev_st;
        end else if (free == LW'(1)) begin
          // need is 2 here: keep the older reg event, lose the store
          push0 = 1'b1;
          drops = 2'd1;
        end else begin
          drops = need;
        end
        if (drops != 2'd0) state_nx = MARK;
      end
      MARK: begin
        // Everything is dropped until the marker is in, so no event can
        // overtake the gap it reports.
        drops = need;
        if (free != '0) begin
          mark_push = 1'b1;
          push0     = 1'b1;
          state_nx  = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign din0 = mark_push ? rec_mark : rec_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      if (drops != 2'd0) ovf_q <= 1'b1;
    end
  end

  trace_fifo2w #(
    .W     ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (rec_st),
    .pop   (tr_ready),
    .valid (fifo_valid),
    .dout  (head),
    .level (fifo_level),
    .free  (free)
  );

  assign tr_valid   = fifo_valid;
  assign tr_kind    = head.kind;
  assign tr_idx     = head.idx;
  assign tr_data    = DATA_W'(head.data);
`ifdef COMMIT_TRACE_STAMP_EN
  assign tr_stamp   = head.stamp;
`else
  assign tr_stamp   = '0;
`endif
  assign ovf_sticky = ovf_q;
  assign level      = fifo_level;

endmodule
